// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central sequencer for the 5-stage RISC-V pipeline.
// Produces enables/clears for PC and the four pipeline registers, resolves
// load-use and taken-branch hazards, and runs the Avalon-MM data-memory
// master for the access held in EX/MEM, freezing the pipe until it completes.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic [31:0]      exmem_alures,
    input  logic [31:0]      exmem_reg2,
    input  logic             avm_waitrequest,
    input  logic             avm_readdatavalid,
    input  logic [31:0]      avm_readdata,
    output logic [31:0]      avm_address,
    output logic             avm_read,
    output logic             avm_write,
    output logic [31:0]      avm_writedata,
    output logic [3:0]       avm_byteenable,
    output logic [31:0]      mem_rdata,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic             exmem_clr,
    output logic             pc_src,
    output logic             bus_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RDATA = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_is_read;
    logic              r_read;
    logic              r_write;
    logic [31:0]       r_mem_rdata;
    logic              r_bus_error;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_mem_op;
    logic w_mem_busy;
    logic w_branch_taken;
    logic w_load_use;
    logic w_timeout;
    logic w_any_stall;

    // Performance counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A load+store combination is treated as a load (read wins).
    assign w_mem_op       = exmem_memread | exmem_memwrite;
    assign w_mem_busy     = w_mem_op & (r_state != S_DONE);
    assign w_branch_taken = exmem_branch & exmem_zero;
    assign w_load_use     = idex_memread & (idex_rd != 5'd0) &
                            ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));
    // Last allowed cycle in REQ/RDATA; the counter would hit TIMEOUT at this edge.
    assign w_timeout      = ((r_state == S_REQ) | (r_state == S_RDATA)) &
                            (r_wait == WAIT_LAST);

    // Address and data come straight from EX/MEM, which is frozen while busy.
    assign avm_address    = exmem_alures;
    assign avm_writedata  = exmem_reg2;
    assign avm_byteenable = 4'hF;
    assign avm_read       = r_read;
    assign avm_write      = r_write;
    assign mem_rdata      = r_mem_rdata;
    assign bus_error      = r_bus_error;
    assign stall_cnt      = r_stall_cnt;
    assign flush_cnt      = r_flush_cnt;

    // Avalon master FSM: issue strobe, wait for accept/data, abort on timeout.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_is_read   <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_mem_rdata <= '0;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_state   <= S_REQ;
                        r_is_read <= exmem_memread;
                        r_read    <= exmem_memread;
                        r_write   <= ~exmem_memread;
                        r_wait    <= '0;
                    end
                end
                S_REQ: begin
                    if (!avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_wait  <= '0;
                        r_state <= r_is_read ? S_RDATA : S_DONE;
                    end else if (w_timeout) begin
                        r_read      <= 1'b0;
                        r_write     <= 1'b0;
                        r_wait      <= '0;
                        r_bus_error <= 1'b1;
                        r_mem_rdata <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_RDATA: begin
                    if (avm_readdatavalid) begin
                        r_mem_rdata <= avm_readdata;
                        r_wait      <= '0;
                        r_state     <= S_DONE;
                    end else if (w_timeout) begin
                        r_wait      <= '0;
                        r_bus_error <= 1'b1;
                        r_mem_rdata <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Hazard priority: memory freeze, then branch flush, then load-use bubble.
    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        memwb_en  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        pc_src    = 1'b0;
        if (w_mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (w_branch_taken) begin
            pc_src    = 1'b1;
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
        end else if (w_load_use) begin
            // ID/EX keeps its enable; the clear overrides it to insert the bubble.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
        end
    end

    assign w_any_stall = ~(pc_en & ifid_en & idex_en & exmem_en & memwb_en);

    // Stall and flush event counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_any_stall)
                r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_branch_taken && !w_mem_busy)
                r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, all checked against a transaction-phase reference model.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Access phases of the reference model
    localparam int PH_NONE   = 0;
    localparam int PH_ISSUE  = 1;
    localparam int PH_DATA   = 2;
    localparam int PH_FINISH = 3;

    logic CLK, RST;
    logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
    logic        idex_memread, exmem_memread, exmem_memwrite, exmem_branch, exmem_zero;
    logic [31:0] exmem_alures, exmem_reg2;
    logic        avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic [31:0] avm_address, avm_writedata, mem_rdata;
    logic        avm_read, avm_write;
    logic [3:0]  avm_byteenable;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_clr, idex_clr, exmem_clr, pc_src, bus_error;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp, n_bad;

    int          m_ph, m_age, m_stall, m_flush;
    bit          m_isread, m_rd_strobe, m_wr_strobe, m_berr, m_last_adv, e_busy;
    logic [31:0] m_rdata;
    logic [4:0]  e_en;
    logic [3:0]  e_clr;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
        .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
        .exmem_alures(exmem_alures), .exmem_reg2(exmem_reg2),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata(avm_readdata), .avm_address(avm_address),
        .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .mem_rdata(mem_rdata),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_clr(ifid_clr), .idex_clr(idex_clr), .exmem_clr(exmem_clr),
        .pc_src(pc_src), .bus_error(bus_error),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_NONE; m_age = 0; m_stall = 0; m_flush = 0;
        m_isread = 0; m_rd_strobe = 0; m_wr_strobe = 0; m_berr = 0;
        m_rdata = '0; m_last_adv = 1;
    endtask

    // Expected hazard controls from the current inputs and model phase
    task automatic model_eval();
        bit mem_op, br, lu;
        mem_op = exmem_memread | exmem_memwrite;
        br     = exmem_branch & exmem_zero;
        lu     = idex_memread && (idex_rd != 0) && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
        e_busy = mem_op && (m_ph != PH_FINISH);
        if (e_busy)   begin e_en = 5'b00000; e_clr = 4'b0000; end
        else if (br)  begin e_en = 5'b11111; e_clr = 4'b1111; end
        else if (lu)  begin e_en = 5'b00111; e_clr = 4'b0100; end
        else          begin e_en = 5'b11111; e_clr = 4'b0000; end
    endtask

    task automatic model_abort();
        m_berr = 1; m_rdata = '0; m_rd_strobe = 0; m_wr_strobe = 0;
        m_age = 0; m_ph = PH_FINISH;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit mem_op;
        mem_op = exmem_memread | exmem_memwrite;
        model_eval();
        if (e_en != 5'b11111) m_stall = (m_stall >= CNT_MAX) ? CNT_MAX : m_stall + 1;
        if (!e_busy && exmem_branch && exmem_zero) m_flush = (m_flush >= CNT_MAX) ? CNT_MAX : m_flush + 1;
        m_last_adv = e_en[1];
        case (m_ph)
            PH_NONE: if (mem_op) begin
                m_ph = PH_ISSUE; m_isread = exmem_memread;
                m_rd_strobe = exmem_memread; m_wr_strobe = !exmem_memread; m_age = 0;
            end
            PH_ISSUE: begin
                if (!avm_waitrequest) begin
                    m_rd_strobe = 0; m_wr_strobe = 0; m_age = 0;
                    m_ph = m_isread ? PH_DATA : PH_FINISH;
                end else if (m_age + 1 >= TIMEOUT) model_abort();
                else m_age++;
            end
            PH_DATA: begin
                if (avm_readdatavalid) begin
                    m_rdata = avm_readdata; m_age = 0; m_ph = PH_FINISH;
                end else if (m_age + 1 >= TIMEOUT) model_abort();
                else m_age++;
            end
            default: m_ph = PH_NONE;
        endcase
    endtask

    task automatic check_all();
        model_eval();
        chk("enables", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(e_en));
        chk("clears_pcsrc", 32'({ifid_clr, idex_clr, exmem_clr, pc_src}), 32'(e_clr));
        chk("strobes", 32'({avm_read, avm_write}), 32'({m_rd_strobe, m_wr_strobe}));
        chk("mem_rdata", mem_rdata, m_rdata);
        chk("bus_error", 32'(bus_error), 32'(m_berr));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        chk("address", avm_address, exmem_alures);
        chk("writedata", avm_writedata, exmem_reg2);
    endtask

    task automatic tick_check();
        #2;
        check_all();
    endtask

    task automatic tick_adv();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        tick_check();
        tick_adv();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        RST = 1'b1;
        ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0; idex_memread = 0;
        exmem_memread = 0; exmem_memwrite = 0; exmem_branch = 0; exmem_zero = 0;
        exmem_alures = '0; exmem_reg2 = '0;
        avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #3;
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_berr", 32'(bus_error), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_flush", 32'(flush_cnt), 32'd0);
        chk("rst_be", 32'(avm_byteenable), 32'hF);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Store, zero-wait slave
        exmem_memwrite = 1; exmem_alures = 32'h100; exmem_reg2 = 32'hDEADBEEF;
        tick_check(); chk("st_idle_frozen", 32'(pc_en), 32'd0); tick_adv();
        tick_check();
        chk("st_write", 32'(avm_write), 32'd1);
        chk("st_addr", avm_address, 32'h100);
        chk("st_data", avm_writedata, 32'hDEADBEEF);
        tick_adv();
        tick_check(); chk("st_done_write", 32'(avm_write), 32'd0); chk("st_done_en", 32'(memwb_en), 32'd1); tick_adv();
        exmem_memwrite = 0;
        tick_check(); chk("st_stall_cnt", 32'(stall_cnt), 32'd2); tick_adv();

        // Load, waitrequest 3 cycles, data 2 cycles after accept
        exmem_memread = 1; exmem_alures = 32'h200; avm_waitrequest = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick_check(); chk("ld_read_wait", 32'(avm_read), 32'd1); chk("ld_frozen", 32'(pc_en), 32'd0); tick_adv();
        end
        avm_waitrequest = 0;
        tick_check(); chk("ld_read_accept", 32'(avm_read), 32'd1); tick_adv();
        tick_check(); chk("ld_rdata_idle", 32'(avm_read), 32'd0); chk("ld_rdata_frozen", 32'(pc_en), 32'd0); tick_adv();
        avm_readdatavalid = 1; avm_readdata = 32'h12345678;
        tick();
        avm_readdatavalid = 0; avm_readdata = '0;
        tick_check(); chk("ld_rdata", mem_rdata, 32'h12345678); chk("ld_done_en", 32'(pc_en), 32'd1); tick_adv();
        exmem_memread = 0;
        tick();

        // Load-use on rs2, then rd = x0
        idex_memread = 1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_rs1 = 5'd3;
        tick_check();
        chk("lu_pc_en", 32'(pc_en), 32'd0); chk("lu_ifid_en", 32'(ifid_en), 32'd0);
        chk("lu_idex_clr", 32'(idex_clr), 32'd1); chk("lu_exmem_en", 32'(exmem_en), 32'd1);
        tick_adv();
        idex_rd = 5'd0; ifid_rs2 = 5'd0;
        tick_check(); chk("lu_x0_pc_en", 32'(pc_en), 32'd1); chk("lu_x0_clr", 32'(idex_clr), 32'd0); tick_adv();

        // Taken branch coinciding with load-use
        idex_rd = 5'd7; ifid_rs1 = 5'd7; exmem_branch = 1; exmem_zero = 1;
        tick_check();
        chk("br_pc_src", 32'(pc_src), 32'd1);
        chk("br_clears", 32'({ifid_clr, idex_clr, exmem_clr}), 32'h7);
        chk("br_no_lu", 32'({pc_en, ifid_en}), 32'h3);
        tick_adv();
        exmem_branch = 0; exmem_zero = 0; idex_memread = 0;
        tick_check(); chk("br_flush_cnt", 32'(flush_cnt), 32'd1); tick_adv();

        // Read with waitrequest stuck high
        exmem_memread = 1; exmem_alures = 32'h300; avm_waitrequest = 1;
        tick();
        for (int k = 0; k < TIMEOUT; k++) begin
            tick_check(); chk("to_read_held", 32'(avm_read), 32'd1); tick_adv();
        end
        tick_check();
        chk("to_read_drop", 32'(avm_read), 32'd0); chk("to_berr", 32'(bus_error), 32'd1);
        chk("to_rdata", mem_rdata, 32'd0); chk("to_resume", 32'(pc_en), 32'd1);
        tick_adv();
        exmem_memread = 0; avm_waitrequest = 0;
        tick_check(); chk("to_berr_sticky", 32'(bus_error), 32'd1); tick_adv();

        // Reset pulsed mid-REQ
        exmem_memread = 1; avm_waitrequest = 1;
        tick();
        tick_check(); chk("rr_read_before", 32'(avm_read), 32'd1);
        RST = 1'b1;
        #1;
        chk("rr_read_async", 32'(avm_read), 32'd0);
        chk("rr_stall", 32'(stall_cnt), 32'd0);
        chk("rr_flush", 32'(flush_cnt), 32'd0);
        chk("rr_berr", 32'(bus_error), 32'd0);
        model_reset();
        exmem_memread = 0; avm_waitrequest = 0;
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        avm_readdatavalid = 1; avm_readdata = 32'hCAFEF00D;
        tick();
        avm_readdatavalid = 0;
        tick_check(); chk("rr_rdvalid_ignored", mem_rdata, 32'd0); tick_adv();

        // Random traffic, second half with a mostly stalled slave
        for (int i = 0; i < 800; i++) begin
            ifid_rs1     = 5'($urandom_range(0, 7));
            ifid_rs2     = 5'($urandom_range(0, 7));
            idex_rd      = 5'($urandom_range(0, 7));
            idex_memread = ($urandom_range(0, 2) == 0);
            exmem_branch = ($urandom_range(0, 3) == 0);
            exmem_zero   = ($urandom_range(0, 1) == 0);
            if (m_last_adv) begin
                exmem_memread  = ($urandom_range(0, 3) == 0);
                exmem_memwrite = ($urandom_range(0, 3) == 0);
                exmem_alures   = $urandom;
                exmem_reg2     = $urandom;
            end
            avm_waitrequest   = (i >= 400) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 0);
            avm_readdatavalid = ($urandom_range(0, 2) == 0);
            avm_readdata      = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
